pp_bank_ctrl: RTL

//   Sequencer for the two-bank ping-pong buffer (PP) datapath.
//   - Steers producer writes into bank A/B and closes a bank when it fills or on in_last.
//   - Hands closed banks to the consumer in order and reads them out under busy backpressure.
//   - Drives bank select, address and enable for both SRAM banks; holds no data itself.

---
 rtl/pp_pkg.sv | 13 +
 rtl/pp_bank_status.sv | 27 ++
 rtl/pp_bank_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pp_pkg.sv
// rtl/pp_pkg.sv - shared types and constants for the ping-pong bank sequencer
package pp_pkg;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_t;

    localparam logic BANK_A   = 1'b0;
    localparam logic BANK_B   = 1'b1;
    localparam int   PP_DEPTH = 8;

endpackage

// File: rtl/pp_bank_status.sv
// rtl/pp_bank_status.sv - per-bank full flag and stored word count
module pp_bank_status #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set,
    input  logic          clr,
    input  logic [CW-1:0] cnt_in,
    output logic          full,
    output logic [CW-1:0] cnt
);

    // set and clr never hit the same bank together (writes are blocked while full)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            cnt  <= '0;
        end else if (set) begin
            full <= 1'b1;
            cnt  <= cnt_in;
        end else if (clr) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/pp_bank_ctrl.sv
// rtl/pp_bank_ctrl.sv - two-bank ping-pong buffer sequencer (write pointer, read FSM, output pipe)
module pp_bank_ctrl
    import pp_pkg::*;
#(
    parameter int  DEPTH = PP_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vaild,
    input  logic          in_last,
    output logic          in_ready,
    input  logic          busy,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic          rd_en,
    output logic          rd_bank,
    output logic [AW-1:0] rd_addr,
    output logic          out_vaild,
    output logic          out_last,
    output logic [1:0]    bank_full,
    output logic          ovf_err
);

    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

    rd_state_t     state_q, state_d;
    logic          rd_bank_d;
    logic [AW-1:0] rd_addr_d;
    logic [AW:0]   cnt_a, cnt_b, rd_cnt, wr_cnt;
    logic          wr_close, rd_last, rd_release, other_full;
    logic          full_a, full_b;

    assign bank_full = {full_b, full_a};
    assign in_ready  = wr_bank ? ~full_b : ~full_a;
    assign wr_en     = in_vaild & in_ready;
    assign wr_close  = wr_en & ((wr_addr == AW'(DEPTH - 1)) | in_last);
    assign wr_cnt    = {1'b0, wr_addr} + CNT_ONE;

    assign rd_cnt     = rd_bank ? cnt_b : cnt_a;
    assign rd_last    = ({1'b0, rd_addr} == (rd_cnt - CNT_ONE));
    assign rd_release = rd_en & rd_last;
    assign other_full = rd_bank ? full_a : full_b;

    pp_bank_status #(.CW(AW + 1)) u_status_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .set    (wr_close & (wr_bank == BANK_A)),
        .clr    (rd_release & (rd_bank == BANK_A)),
        .cnt_in (wr_cnt),
        .full   (full_a),
        .cnt    (cnt_a)
    );

    pp_bank_status #(.CW(AW + 1)) u_status_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .set    (wr_close & (wr_bank == BANK_B)),
        .clr    (rd_release & (rd_bank == BANK_B)),
        .cnt_in (wr_cnt),
        .full   (full_b),
        .cnt    (cnt_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= BANK_A;
            wr_addr <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (wr_close) begin
                wr_bank <= ~wr_bank;
                wr_addr <= '0;
            end else if (wr_en) begin
                wr_addr <= wr_addr + AW'(1);
            end
            if (in_vaild & ~in_ready)
                ovf_err <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank;
        rd_addr_d = rd_addr;
        rd_en     = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (rd_bank ? full_b : full_a) begin
                    state_d   = RD_RUN;
                    rd_addr_d = '0;
                end
            end
            RD_RUN: begin
                rd_en = ~busy;
                if (rd_en) begin
                    if (rd_last) begin
                        // chain straight into the other bank when it is already closed
                        rd_bank_d = ~rd_bank;
                        rd_addr_d = '0;
                        state_d   = other_full ? RD_RUN : RD_IDLE;
                    end else begin
                        rd_addr_d = rd_addr + AW'(1);
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RD_IDLE;
            rd_bank   <= BANK_A;
            rd_addr   <= '0;
            out_vaild <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_bank   <= rd_bank_d;
            rd_addr   <= rd_addr_d;
            out_vaild <= rd_en;
            out_last  <= rd_release;
        end
    end

endmodule
